// File: rtl/decode_hazard_sequencer.sv
// -----------------------------------------------------------------------------
// decode_hazard_sequencer
//
// Sequences the fetch/decode/execute boundary of the 5-stage CPU. It decides
// each cycle whether the PC and FetchDecode_register must hold, whether
// FetchDecode_register must be flushed to a nop, and whether the nop mux in
// front of DecodeExecute_register must inject a bubble.
//
// Three event types are resolved, in this priority order while running:
//   1. load-use hazard between the load in execute and the instruction in decode
//   2. taken branch resolved by the comparator in decode
//   3. multi-cycle vector op that occupies execute for VEC_LATENCY cycles
// A saturating counter records every cycle in which a bubble is injected.
//
// Ports:
//   clk              clock, all state changes on the rising edge
//   reset            asynchronous reset, active low (0 = in reset)
//   rs1_decode       source register 1 of the decode instruction
//   rs2_decode       source register 2 of the decode instruction
//   vector_op_decode decode instruction is a vector ALU op
//   branch_taken     comparator resolved a taken branch in decode
//   rd_execute       destination register of the execute instruction
//   load_execute     execute instruction is a load
//   count_clear      synchronous clear of bubble_count (wins over increment)
//   stall_pc         hold PC
//   stall_fd         hold FetchDecode_register
//   flush_fd         clear FetchDecode_register to nop
//   nop_de           select the nop input of the DecodeExecute mux
//   busy             sequencer is in a multi-cycle state
//   bubble_count     number of cycles with nop_de=1, saturating
// -----------------------------------------------------------------------------
module decode_hazard_sequencer #(
  parameter int LOAD_BUBBLES   = 1,
  parameter int BRANCH_BUBBLES = 1,
  parameter int VEC_LATENCY    = 4,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_decode,
  input  logic [4:0]       rs2_decode,
  input  logic             vector_op_decode,
  input  logic             branch_taken,
  input  logic [4:0]       rd_execute,
  input  logic             load_execute,
  input  logic             count_clear,
  output logic             stall_pc,
  output logic             stall_fd,
  output logic             flush_fd,
  output logic             nop_de,
  output logic             busy,
  output logic [CNT_W-1:0] bubble_count
);

  // The first cycle of every event is handled in RUN, so the down-counter
  // only has to cover the remaining cycles: at most MAX_LAT-2.
  localparam int MAX_LB_BR = (LOAD_BUBBLES > BRANCH_BUBBLES) ? LOAD_BUBBLES : BRANCH_BUBBLES;
  localparam int MAX_LAT   = (MAX_LB_BR > VEC_LATENCY) ? MAX_LB_BR : VEC_LATENCY;
  localparam int CNT_BITS  = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_BITS-1:0] LOAD_INIT =
    (LOAD_BUBBLES > 1) ? CNT_BITS'(LOAD_BUBBLES - 2) : '0;
  localparam logic [CNT_BITS-1:0] BRANCH_INIT =
    (BRANCH_BUBBLES > 1) ? CNT_BITS'(BRANCH_BUBBLES - 2) : '0;
  localparam logic [CNT_BITS-1:0] VEC_INIT =
    (VEC_LATENCY > 1) ? CNT_BITS'(VEC_LATENCY - 2) : '0;

  typedef enum logic [1:0] {
    RUN,
    LOAD_STALL,
    BR_FLUSH,
    VEC_BUSY
  } state_e;

  state_e             state_q;
  state_e             state_d;
  logic [CNT_BITS-1:0] cnt_q;
  logic [CNT_BITS-1:0] cnt_d;
  logic [CNT_W-1:0]   bubble_count_q;
  logic [CNT_W-1:0]   bubble_count_d;

  logic hazard_lu;
  logic stall_c;
  logic flush_c;
  logic nop_c;
  logic busy_c;

  // Register x0 is hard-wired to zero, so a load targeting it never creates
  // a real dependency.
  assign hazard_lu = load_execute && (rd_execute != 5'd0) &&
                     ((rd_execute == rs1_decode) || (rd_execute == rs2_decode));

  // Next-state and control decode. While a hazard is present the branch
  // comparator saw stale operands, so branch and vector requests from that
  // cycle are dropped and re-evaluated once the stall is over. Outputs are
  // forced low while reset is asserted so a stall is aborted at once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    flush_c = 1'b0;
    nop_c   = 1'b0;
    busy_c  = 1'b0;

    unique case (state_q)
      RUN: begin
        if (hazard_lu) begin
          stall_c = 1'b1;
          nop_c   = 1'b1;
          if (LOAD_BUBBLES > 1) begin
            state_d = LOAD_STALL;
            cnt_d   = LOAD_INIT;
          end
        end else if (branch_taken) begin
          flush_c = 1'b1;
          if (BRANCH_BUBBLES > 1) begin
            state_d = BR_FLUSH;
            cnt_d   = BRANCH_INIT;
          end
        end else if (vector_op_decode) begin
          if (VEC_LATENCY > 1) begin
            state_d = VEC_BUSY;
            cnt_d   = VEC_INIT;
          end
        end
      end

      LOAD_STALL: begin
        stall_c = 1'b1;
        nop_c   = 1'b1;
        busy_c  = 1'b1;
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end

      BR_FLUSH: begin
        flush_c = 1'b1;
        busy_c  = 1'b1;
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end

      VEC_BUSY: begin
        stall_c = 1'b1;
        nop_c   = 1'b1;
        busy_c  = 1'b1;
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end

      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    if (!reset) begin
      stall_c = 1'b0;
      flush_c = 1'b0;
      nop_c   = 1'b0;
      busy_c  = 1'b0;
    end
  end

  // Bubble counter: clear wins over increment, and the count sticks at
  // all-ones instead of wrapping.
  always_comb begin
    bubble_count_d = bubble_count_q;
    if (count_clear) begin
      bubble_count_d = '0;
    end else if (nop_c && (bubble_count_q != '1)) begin
      bubble_count_d = bubble_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      bubble_count_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign stall_pc     = stall_c;
  assign stall_fd     = stall_c;
  assign flush_fd     = flush_c;
  assign nop_de       = nop_c;
  assign busy         = busy_c;
  assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_decode_hazard_sequencer.sv
// -----------------------------------------------------------------------------
// tb_decode_hazard_sequencer
//
// Directed bench for decode_hazard_sequencer. Instance u_dut_a uses the
// default parameters; u_dut_b uses LOAD_BUBBLES=3, BRANCH_BUBBLES=2,
// VEC_LATENCY=1 and a 4-bit bubble counter so that multi-cycle load stalls,
// multi-cycle flushes and counter saturation can be reached quickly.
// Control outputs are compared as the vector
// {stall_pc, stall_fd, flush_fd, nop_de, busy}.
// -----------------------------------------------------------------------------
module tb_decode_hazard_sequencer;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       vec;
    logic       br;
    logic [4:0] rd;
    logic       ld;
    logic       clr;
  } stim_t;

  localparam stim_t IDLE = '0;

  logic  clk;
  logic  reset_a;
  logic  reset_b;
  stim_t stim_a;
  stim_t stim_b;

  logic        stall_pc_a, stall_fd_a, flush_fd_a, nop_de_a, busy_a;
  logic [15:0] bubble_count_a;
  logic        stall_pc_b, stall_fd_b, flush_fd_b, nop_de_b, busy_b;
  logic [3:0]  bubble_count_b;

  logic [4:0] obs_a;
  logic [4:0] obs_b;

  int tests_run;
  int tests_failed;

  assign obs_a = {stall_pc_a, stall_fd_a, flush_fd_a, nop_de_a, busy_a};
  assign obs_b = {stall_pc_b, stall_fd_b, flush_fd_b, nop_de_b, busy_b};

  decode_hazard_sequencer u_dut_a (
    .clk              (clk),
    .reset            (reset_a),
    .rs1_decode       (stim_a.rs1),
    .rs2_decode       (stim_a.rs2),
    .vector_op_decode (stim_a.vec),
    .branch_taken     (stim_a.br),
    .rd_execute       (stim_a.rd),
    .load_execute     (stim_a.ld),
    .count_clear      (stim_a.clr),
    .stall_pc         (stall_pc_a),
    .stall_fd         (stall_fd_a),
    .flush_fd         (flush_fd_a),
    .nop_de           (nop_de_a),
    .busy             (busy_a),
    .bubble_count     (bubble_count_a)
  );

  decode_hazard_sequencer #(
    .LOAD_BUBBLES   (3),
    .BRANCH_BUBBLES (2),
    .VEC_LATENCY    (1),
    .CNT_W          (4)
  ) u_dut_b (
    .clk              (clk),
    .reset            (reset_b),
    .rs1_decode       (stim_b.rs1),
    .rs2_decode       (stim_b.rs2),
    .vector_op_decode (stim_b.vec),
    .branch_taken     (stim_b.br),
    .rd_execute       (stim_b.rd),
    .load_execute     (stim_b.ld),
    .count_clear      (stim_b.clr),
    .stall_pc         (stall_pc_b),
    .stall_fd         (stall_fd_b),
    .flush_fd         (flush_fd_b),
    .nop_de           (nop_de_b),
    .busy             (busy_b),
    .bubble_count     (bubble_count_b)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic stim_t mkStim(input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic vec, input logic br,
                                   input logic [4:0] rd, input logic ld);
    stim_t s;
    s     = IDLE;
    s.rs1 = rs1;
    s.rs2 = rs2;
    s.vec = vec;
    s.br  = br;
    s.rd  = rd;
    s.ld  = ld;
    return s;
  endfunction

  // Drives the stimulus of one instance shortly after a rising edge.
  task automatic applyStimulus(input bit sel_b, input stim_t s);
    @(posedge clk);
    #1;
    if (sel_b) stim_b = s;
    else       stim_a = s;
  endtask

  task automatic checkOutput(input string tag, input logic [4:0] observed,
                             input logic [4:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
      $error("[TB] %s observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic checkCount(input string tag, input logic [15:0] observed,
                            input logic [15:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      $error("[TB] %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // Reset held with every hazard input active
    reset_a = 1'b0;
    reset_b = 1'b0;
    stim_a  = mkStim(5'd0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1);
    stim_b  = mkStim(5'd3, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("a_reset_outs", obs_a, 5'b00000);
    checkCount ("a_reset_cnt", bubble_count_a, 16'd0);
    checkOutput("b_reset_outs", obs_b, 5'b00000);

    // Release with no events
    @(posedge clk);
    #1;
    reset_a = 1'b1;
    reset_b = 1'b1;
    stim_a  = IDLE;
    stim_b  = IDLE;
    @(negedge clk);
    checkOutput("a_release_outs", obs_a, 5'b00000);
    checkCount ("a_release_cnt", bubble_count_a, 16'd0);

    // Load-use through rs2, single bubble
    applyStimulus(1'b0, mkStim(5'd0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1));
    @(negedge clk);
    checkOutput("a_lu_rs2", obs_a, 5'b11010);
    checkCount ("a_lu_rs2_cnt0", bubble_count_a, 16'd0);

    applyStimulus(1'b0, IDLE);
    @(negedge clk);
    checkOutput("a_lu_done", obs_a, 5'b00000);
    checkCount ("a_lu_cnt1", bubble_count_a, 16'd1);

    // Load to x0 matching both sources never stalls
    applyStimulus(1'b0, mkStim(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1));
    @(negedge clk);
    checkOutput("a_rd_zero", obs_a, 5'b00000);

    // Match without a load is not a hazard
    applyStimulus(1'b0, mkStim(5'd4, 5'd0, 1'b0, 1'b0, 5'd4, 1'b0));
    @(negedge clk);
    checkOutput("a_no_load", obs_a, 5'b00000);

    // Load-use through rs1 beats a same-cycle taken branch
    applyStimulus(1'b0, mkStim(5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1));
    @(negedge clk);
    checkOutput("a_lu_beats_br", obs_a, 5'b11010);

    // Branch re-evaluated next cycle: one flush cycle, no stall
    applyStimulus(1'b0, mkStim(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0));
    @(negedge clk);
    checkOutput("a_br_flush", obs_a, 5'b00100);
    checkCount ("a_br_cnt", bubble_count_a, 16'd2);

    applyStimulus(1'b0, IDLE);
    @(negedge clk);
    checkOutput("a_br_done", obs_a, 5'b00000);

    // Vector op: issue cycle clean, then three busy stall cycles
    applyStimulus(1'b0, mkStim(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0));
    @(negedge clk);
    checkOutput("a_vec_issue", obs_a, 5'b00000);

    applyStimulus(1'b0, mkStim(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1));
    @(negedge clk);
    checkOutput("a_vec_busy1", obs_a, 5'b11011);

    applyStimulus(1'b0, IDLE);
    @(negedge clk);
    checkOutput("a_vec_busy2", obs_a, 5'b11011);

    applyStimulus(1'b0, IDLE);
    @(negedge clk);
    checkOutput("a_vec_busy3", obs_a, 5'b11011);

    // Back-to-back vector op pays the full latency again
    applyStimulus(1'b0, mkStim(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0));
    @(negedge clk);
    checkOutput("a_vec2_issue", obs_a, 5'b00000);
    checkCount ("a_vec_cnt5", bubble_count_a, 16'd5);

    applyStimulus(1'b0, IDLE);
    @(negedge clk);
    checkOutput("a_vec2_busy1", obs_a, 5'b11011);

    applyStimulus(1'b0, mkStim(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0));
    @(negedge clk);
    checkOutput("a_vec2_busy2_br", obs_a, 5'b11011);

    applyStimulus(1'b0, IDLE);
    @(negedge clk);
    checkOutput("a_vec2_busy3", obs_a, 5'b11011);

    applyStimulus(1'b0, IDLE);
    @(negedge clk);
    checkOutput("a_vec2_done", obs_a, 5'b00000);
    checkCount ("a_vec_cnt8", bubble_count_a, 16'd8);

    // Three-bubble load-use on instance b
    applyStimulus(1'b1, mkStim(5'd3, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1));
    @(negedge clk);
    checkOutput("b_lu_first", obs_b, 5'b11010);

    applyStimulus(1'b1, IDLE);
    @(negedge clk);
    checkOutput("b_lu_second", obs_b, 5'b11011);

    applyStimulus(1'b1, IDLE);
    @(negedge clk);
    checkOutput("b_lu_third", obs_b, 5'b11011);

    applyStimulus(1'b1, IDLE);
    @(negedge clk);
    checkOutput("b_lu_done", obs_b, 5'b00000);
    checkCount ("b_lu_cnt3", {12'd0, bubble_count_b}, 16'd3);

    // Two-cycle branch flush, the second cycle marked busy
    applyStimulus(1'b1, mkStim(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0));
    @(negedge clk);
    checkOutput("b_br_first", obs_b, 5'b00100);

    applyStimulus(1'b1, IDLE);
    @(negedge clk);
    checkOutput("b_br_second", obs_b, 5'b00101);

    // Single-cycle vector op never leaves RUN
    applyStimulus(1'b1, mkStim(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0));
    @(negedge clk);
    checkOutput("b_vec_issue", obs_b, 5'b00000);

    applyStimulus(1'b1, IDLE);
    @(negedge clk);
    checkOutput("b_vec_after", obs_b, 5'b00000);
    checkCount ("b_cnt_still3", {12'd0, bubble_count_b}, 16'd3);

    // Reset asserted during the second stall cycle aborts the stall
    applyStimulus(1'b1, mkStim(5'd0, 5'd6, 1'b0, 1'b0, 5'd6, 1'b1));
    @(negedge clk);
    checkOutput("b_lu2_first", obs_b, 5'b11010);

    applyStimulus(1'b1, IDLE);
    @(negedge clk);
    checkOutput("b_lu2_second", obs_b, 5'b11011);
    checkCount ("b_lu2_cnt4", {12'd0, bubble_count_b}, 16'd4);
    #1;
    reset_b = 1'b0;
    #1;
    checkOutput("b_async_reset", obs_b, 5'b00000);
    checkCount ("b_async_reset_cnt", {12'd0, bubble_count_b}, 16'd0);

    @(posedge clk);
    #1;
    reset_b = 1'b1;
    @(negedge clk);
    checkOutput("b_after_reset", obs_b, 5'b00000);

    // Continuous hazard: every edge injects a bubble until saturation
    applyStimulus(1'b1, mkStim(5'd2, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1));
    repeat (14) @(posedge clk);
    @(negedge clk);
    checkCount ("b_cnt14", {12'd0, bubble_count_b}, 16'd14);
    repeat (6) @(posedge clk);
    #1;
    stim_b = IDLE;
    @(negedge clk);
    checkOutput("b_sat_state", obs_b, 5'b11011);
    checkCount ("b_cnt_sat", {12'd0, bubble_count_b}, 16'd15);

    // Clear coincident with a bubble cycle wins
    stim_b.clr = 1'b1;
    @(posedge clk);
    #1;
    stim_b.clr = 1'b0;
    @(negedge clk);
    checkOutput("b_clear_state", obs_b, 5'b00000);
    checkCount ("b_clear_cnt", {12'd0, bubble_count_b}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
